alu_seq: RTL

- Parametrised, registered add/subtract/logic unit with a status flag set, plus a multi-cycle unsigned shift-add multiplier.
- Next generation of the team's 4-bit combinational adder/subtractor: width is generic, the operation set is wider, a sign/overflow flag is added, and operations are issued through a start/busy/done handshake.
- Sits between the lab datapath register file and the display/flag logic as the single arithmetic resource.

---
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered add/sub/logic unit with status flags and a multi-cycle
// unsigned shift-add multiplier, issued through a start/busy/done handshake.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zf,
    output logic             cf,
    output logic             of,
    output logic             nf
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_issue_alu;
    logic w_issue_mul;
    logic w_mul_last;

    // Multiplier state: the multiplier sits in the low half of the
    // accumulator and is consumed one bit per cycle as the product shifts in.
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    // Single-cycle datapath
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_cf;
    logic             w_of;
    logic             w_wr_res;

    // Registered outputs
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_done;
    logic             r_zf;
    logic             r_cf;
    logic             r_of;
    logic             r_nf;

    // Two's-complement overflow for a+b: same-sign operands, result sign differs.
    function automatic logic f_add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Two's-complement overflow for a-b: opposite-sign operands, result sign differs from a.
    function automatic logic f_sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start && (op == OP_MUL)) w_state_next = S_MUL;
            S_MUL:   if (w_mul_last)              w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: handshake status and issue/complete strobes
    always_comb begin
        busy        = (r_state == S_MUL);
        w_issue_alu = (r_state == S_IDLE) && start && (op != OP_MUL);
        w_issue_mul = (r_state == S_IDLE) && start && (op == OP_MUL);
        w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
    end

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the whole accumulator (with the add carry) right.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // Multiplier operand latch and iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_issue_mul) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
        end else if (r_state == S_MUL) begin
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Single-cycle result and flags; CMP computes the SUB difference but
    // leaves the result registers untouched.
    always_comb begin
        w_add    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        w_sub    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        w_res    = '0;
        w_cf     = 1'b0;
        w_of     = 1'b0;
        w_wr_res = 1'b1;
        case (op)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_cf  = w_add[WIDTH];
                w_of  = f_add_ovf(a[WIDTH-1], b[WIDTH-1], w_add[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                // Bit WIDTH of the extended difference is the borrow out.
                w_res    = w_sub[WIDTH-1:0];
                w_cf     = w_sub[WIDTH];
                w_of     = f_sub_ovf(a[WIDTH-1], b[WIDTH-1], w_sub[WIDTH-1]);
                w_wr_res = (op != OP_CMP);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SHL1: begin
                w_res = {a[WIDTH-2:0], 1'b0};
                w_cf  = a[WIDTH-1];
                w_of  = a[WIDTH-1] ^ a[WIDTH-2];
            end
            default: w_wr_res = 1'b0;
        endcase
    end

    // Output registers: written on single-cycle issue or on the last MUL step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zf        <= 1'b0;
            r_cf        <= 1'b0;
            r_of        <= 1'b0;
            r_nf        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_issue_alu) begin
                r_done <= 1'b1;
                if (w_wr_res) begin
                    r_result    <= w_res;
                    r_result_hi <= '0;
                end
                r_zf <= (w_res == '0);
                r_nf <= w_res[WIDTH-1];
                r_cf <= w_cf;
                r_of <= w_of;
            end else if (w_mul_last) begin
                r_done      <= 1'b1;
                r_result    <= w_acc_next[WIDTH-1:0];
                r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                r_zf        <= (w_acc_next == '0);
                r_nf        <= w_acc_next[2*WIDTH-1];
                r_cf        <= |w_acc_next[2*WIDTH-1:WIDTH];
                r_of        <= 1'b0;
            end
        end
    end

    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign of        = r_of;
    assign nf        = r_nf;

endmodule
